// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester round-robin arbiter driving a ready-handshake
//            memory, with transaction timeout and per-requester read data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic        a_len,
    input  logic [23:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_done,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic        b_len,
    input  logic [23:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_done,
    output logic [31:0] b_rdata,
    output logic        err,
    output logic [23:0] mem_addr,
    output logic        mem_length,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_enable,
    input  logic        mem_rdy,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din
);

    localparam int              c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE   = 3'd1;
    localparam logic [2:0] c_WAIT_LO = 3'd2;
    localparam logic [2:0] c_WAIT_HI = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic            r_rdy_meta;
    logic            r_rdy_sync;
    logic            r_last_b;
    logic            r_gnt_b;
    logic            r_wr;
    logic            r_len;
    logic [23:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [c_CW-1:0] r_cnt;
    logic            r_tmo;
    logic [31:0]     r_a_rdata;
    logic [31:0]     r_b_rdata;

    logic            w_grant;
    logic            w_pick_b;
    logic            w_timeout;
    logic            w_ok;
    logic            w_expired;
    logic [31:0]     w_rd_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_meta <= 1'b0;
            r_rdy_sync <= 1'b0;
        end else begin
            r_rdy_meta <= mem_rdy;
            r_rdy_sync <= r_rdy_meta;
        end
    end

    // Ties go to whichever requester was not served last.
    assign w_grant   = (r_state == c_IDLE) && r_rdy_sync && (a_req || b_req);
    assign w_pick_b  = b_req && (!a_req || !r_last_b);
    assign w_timeout = (r_cnt == c_CNT_LAST);
    assign w_ok      = (r_state == c_WAIT_HI) && r_rdy_sync;
    assign w_expired = w_timeout &&
                       (((r_state == c_WAIT_LO) && r_rdy_sync) ||
                        ((r_state == c_WAIT_HI) && !r_rdy_sync));
    assign w_rd_value = w_expired ? 32'h0 :
                        (r_len ? mem_dout : {24'h0, mem_dout[7:0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_grant) w_next_state = c_ISSUE;
            c_ISSUE:   w_next_state = c_WAIT_LO;
            c_WAIT_LO: begin
                if (!r_rdy_sync)    w_next_state = c_WAIT_HI;
                else if (w_timeout) w_next_state = c_DONE;
            end
            c_WAIT_HI: if (r_rdy_sync || w_timeout) w_next_state = c_DONE;
            c_DONE:    w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b  <= 1'b1;
            r_gnt_b   <= 1'b0;
            r_wr      <= 1'b0;
            r_len     <= 1'b0;
            r_addr    <= 24'h0;
            r_wdata   <= 32'h0;
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
            r_a_rdata <= 32'h0;
            r_b_rdata <= 32'h0;
        end else begin
            if (w_grant) begin
                r_gnt_b <= w_pick_b;
                r_wr    <= w_pick_b ? b_wr    : a_wr;
                r_len   <= w_pick_b ? b_len   : a_len;
                r_addr  <= w_pick_b ? b_addr  : a_addr;
                r_wdata <= w_pick_b ? b_wdata : a_wdata;
            end
            if (r_state == c_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == c_WAIT_LO) || (r_state == c_WAIT_HI)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ok || w_expired) begin
                r_tmo <= w_expired;
                if (!r_wr) begin
                    if (r_gnt_b) r_b_rdata <= w_rd_value;
                    else         r_a_rdata <= w_rd_value;
                end
            end
            if (r_state == c_DONE) begin
                r_last_b <= r_gnt_b;
            end
        end
    end

    // Strobes are decoded from state so an asynchronous reset clears them at once.
    always_comb begin
        mem_enable = (r_state == c_ISSUE) || (r_state == c_WAIT_LO);
        mem_rd     = mem_enable && !r_wr;
        mem_wr     = mem_enable && r_wr;
        mem_addr   = r_addr;
        mem_length = r_len;
        mem_din    = r_len ? r_wdata : {4{r_wdata[7:0]}};
        a_done     = (r_state == c_DONE) && !r_gnt_b;
        b_done     = (r_state == c_DONE) && r_gnt_b;
        err        = (r_state == c_DONE) && r_tmo;
        a_rdata    = r_a_rdata;
        b_rdata    = r_b_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_wr = 1'b0, a_len = 1'b0;
    logic [23:0] a_addr = 24'h0;
    logic [31:0] a_wdata = 32'h0;
    logic        b_req = 1'b0, b_wr = 1'b0, b_len = 1'b0;
    logic [23:0] b_addr = 24'h0;
    logic [31:0] b_wdata = 32'h0;
    logic        a_done, b_done, err;
    logic [31:0] a_rdata, b_rdata;
    logic [23:0] mem_addr;
    logic        mem_length, mem_rd, mem_wr, mem_enable;
    logic        mem_rdy;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_len(a_len), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_len(b_len), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_done(b_done), .b_rdata(b_rdata),
        .err(err), .mem_addr(mem_addr), .mem_length(mem_length),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_enable(mem_enable),
        .mem_rdy(mem_rdy), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] din_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Behavioural memory: ready drops on a strobe and returns after lat cycles.
    logic [7:0]  mem [int];
    int          lat = 3;
    bit          hang = 1'b0;
    int          en_cnt = 0;
    logic [23:0] m_ad;
    logic        m_wr, m_len;
    logic [31:0] m_rv;

    function automatic logic [7:0] rd(input int a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    initial begin
        mem_rdy  = 1'b1;
        mem_dout = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_enable) en_cnt++;
            if (rst_n && mem_enable && !hang) begin
                m_ad  = mem_addr;
                m_wr  = mem_wr;
                m_len = mem_length;
                if (m_wr) begin
                    if (din_q.size() == 0) fail_now("unexpected_write");
                    else check("mem_din", mem_din, din_q.pop_front());
                    if (m_len) begin
                        for (int k = 0; k < 4; k++) mem[int'(m_ad) + k] = mem_din[8*k +: 8];
                    end else begin
                        mem[int'(m_ad)] = mem_din[7:0];
                    end
                    m_rv = 32'hDEAD_BEEF;
                end else begin
                    m_rv = m_len ? {rd(int'(m_ad) + 3), rd(int'(m_ad) + 2),
                                    rd(int'(m_ad) + 1), rd(int'(m_ad))}
                                 : {24'hC0FFEE, rd(int'(m_ad))};
                end
                mem_rdy = 1'b0;
                repeat (lat) @(negedge clk);
                mem_dout = m_rv;
                mem_rdy  = 1'b1;
                for (int k = 0; k < 50 && mem_enable; k++) @(negedge clk);
            end
        end
    end

    // Monitor: every done pops one expected response.
    exp_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (a_done && b_done) fail_now("dual_done");
                if (a_done || b_done) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        m_e = exp_q.pop_front();
                        check("done_who", {31'b0, b_done}, {31'b0, m_e.who});
                        check("rdata", b_done ? b_rdata : a_rdata, m_e.rdata);
                        check("err", {31'b0, err}, {31'b0, m_e.err});
                    end
                end else if (err) begin
                    fail_now("err_without_done");
                end
            end
        end
    end

    task automatic set_req(input bit who, input bit wr, input bit len,
                           input logic [23:0] addr, input logic [31:0] wd);
        if (who) begin
            b_req = 1'b1; b_wr = wr; b_len = len; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_wr = wr; a_len = len; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic push_exp(input bit who, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        e.who   = who;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input bit who, input bit wr, input bit len,
                          input logic [23:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_din, input logic [31:0] exp_rd,
                          input bit exp_err);
        bit got = 1'b0;
        push_exp(who, exp_rd, exp_err);
        if (wr && !hang) din_q.push_back(exp_din);
        @(negedge clk);
        set_req(who, wr, len, addr, wd);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = who ? b_done : a_done;
        end
        if (!got) fail_now("done_wait");
        if (who) b_req = 1'b0; else a_req = 1'b0;
    endtask

    // Both requesters raise reads in the same cycle.
    task automatic do_both(input bit first,
                           input logic [23:0] a_ad, input bit a_ln, input logic [31:0] a_exp,
                           input logic [23:0] b_ad, input bit b_ln, input logic [31:0] b_exp);
        bit got_a = 1'b0, got_b = 1'b0;
        push_exp(first, first ? b_exp : a_exp, 1'b0);
        push_exp(!first, first ? a_exp : b_exp, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, a_ln, a_ad, 32'h0);
        set_req(1'b1, 1'b0, b_ln, b_ad, 32'h0);
        for (int i = 0; i < 400 && !(got_a && got_b); i++) begin
            @(negedge clk);
            if (a_done) begin got_a = 1'b1; a_req = 1'b0; end
            if (b_done) begin got_b = 1'b1; b_req = 1'b0; end
        end
        if (!(got_a && got_b)) fail_now("both_done_wait");
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    int  en_start;
    bit  seen;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'b0, mem_enable, mem_rd, mem_wr}, 32'h0);
        check("rst_done_err", {29'b0, a_done, b_done, err}, 32'h0);
        check("rst_rdata", a_rdata | b_rdata, 32'h0);
        check("rst_addr_din", {8'h0, mem_addr} | mem_din, 32'h0);
        rst_n = 1'b1;

        do_req(1'b0, 1'b1, 1'b1, 24'h000010, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0);
        do_req(1'b0, 1'b0, 1'b1, 24'h000010, 32'h0,        32'h0,        32'h12345678, 1'b0);
        do_req(1'b1, 1'b1, 1'b0, 24'h000013, 32'hFFFFFFAB, 32'hABABABAB, 32'h00000000, 1'b0);
        do_req(1'b1, 1'b0, 1'b0, 24'h000013, 32'h0,        32'h0,        32'h000000AB, 1'b0);
        // Last grant was B, so A wins this tie.
        do_both(1'b0, 24'h000010, 1'b1, 32'hAB345678, 24'h000011, 1'b0, 32'h00000056);
        do_req(1'b0, 1'b1, 1'b1, 24'h000020, 32'hCAFEF00D, 32'hCAFEF00D, 32'hAB345678, 1'b0);
        // Last grant was A, so B wins this tie.
        do_both(1'b1, 24'h000021, 1'b0, 32'h000000F0, 24'h000020, 1'b1, 32'hCAFEF00D);

        hang     = 1'b1;
        en_start = en_cnt;
        do_req(1'b0, 1'b0, 1'b1, 24'h000030, 32'h0, 32'h0, 32'h00000000, 1'b1);
        check("timeout_enable_cycles", en_cnt - en_start, 32'd16);
        hang = 1'b0;
        do_req(1'b0, 1'b0, 1'b0, 24'h000012, 32'h0, 32'h0, 32'h00000034, 1'b0);

        // Abort a read while it waits for ready to return.
        lat = 8;
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 24'h000010, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mem_enable;
        end
        if (!seen) fail_now("abort_issue_wait");
        for (int i = 0; i < 50 && mem_enable; i++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {29'b0, mem_enable, mem_rd, mem_wr}, 32'h0);
        check("abort_done", {30'b0, a_done, err}, 32'h0);
        check("abort_rdata", a_rdata, 32'h0);
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lat = 3;
        do_req(1'b1, 1'b0, 1'b1, 24'h000010, 32'h0, 32'h0, 32'hAB345678, 1'b0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent waiting on mem_rdy per transaction before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req / b_req  input  1  requester A/B transaction request, held high until matching done.
REQ-005 a_wr / b_wr  input  1  1 = write, 0 = read.
REQ-006 a_len / b_len  input  1  0 = byte, 1 = word.
REQ-007 a_addr / b_addr  input  24  byte address.
REQ-008 a_wdata / b_wdata  input  32  write data; byte writes use bits [7:0].
REQ-009 a_done / b_done  output  1  one-cycle completion pulse to requester A/B.
REQ-010 a_rdata / b_rdata  output  32  read result, valid with done, held until next done to the same requester.
REQ-011 err  output  1  one-cycle pulse coincident with a done that ended by timeout.
REQ-012 mem_addr  output  24  memory address.
REQ-013 mem_length  output  1  memory Length (0 byte, 1 word).
REQ-014 mem_rd / mem_wr / mem_enable  output  1  memory strobes.
REQ-015 mem_rdy  input  1  memory ready (high = idle), asynchronous to clk; double-flop synchronized before use.
REQ-016 mem_dout  input  32  memory DataOut.
REQ-017 mem_din  output  32  memory DataIn.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE; one-hot or binary, designer's choice.
REQ-019 IDLE: stays in IDLE while synchronized mem_rdy is 0 or no req is high.
REQ-020 Arbitration in IDLE: single requester -> granted; both -> requester not granted last (round-robin); last_grant resets to B so A wins the first tie.
REQ-021 On grant, addr, len, wr, wdata and grant id are latched; mem_* outputs are driven only from latched values until IDLE is re-entered; req changes mid-transaction are ignored.
REQ-022 mem_din: word -> wdata; byte -> wdata[7:0] replicated on all four byte lanes.
REQ-023 ISSUE (1 cycle): mem_enable=1, mem_rd=~wr, mem_wr=wr; strobes stay asserted through WAIT_LO and drop on entry to WAIT_HI.
REQ-024 WAIT_LO: advance to WAIT_HI when synchronized mem_rdy = 0.
REQ-025 WAIT_HI: advance to DONE when synchronized mem_rdy = 1; mem_dout sampled that cycle.
REQ-026 Read data: word -> mem_dout; byte -> {24'b0, mem_dout[7:0]}; write -> rdata unchanged.
REQ-027 Timeout counter clears on ISSUE, increments each cycle in WAIT_LO/WAIT_HI; on reaching TIMEOUT -> DONE with err=1 and, for reads, rdata = 32'h0.
REQ-028 DONE (1 cycle): done pulse to latched requester only, mem_enable=0, update last_grant, then IDLE.
REQ-029 Minimum transaction: grant cycle N, ISSUE N+1, done no earlier than N+4; next grant no earlier than the cycle after DONE.
REQ-030 No two dones in one cycle; a_done and b_done are mutually exclusive.

Reset
REQ-031 rst_n low: state IDLE, all outputs 0 (mem strobes, done, err, rdata, mem_addr, mem_din), counter 0, last_grant = B, synchronizer flops 0.
REQ-032 Reset mid-transaction drops strobes immediately; no done or err is produced for the aborted transaction.
REQ-033 After rst_n release, no issue until synchronized mem_rdy has been 1 for one cycle.

Verification
REQ-034 A word write addr 0x000010 data 0x12345678, then A word read 0x000010 -> a_done once each, a_rdata = 0x12345678, b_done never.
REQ-035 B byte write addr 0x000013 data 0xAB, then B byte read 0x000013 -> mem_din = 0xABABABAB on write, b_rdata = 0x000000AB.
REQ-036 a_req and b_req raised same cycle after reset, held through two transactions -> A served first, B second, dones on separate cycles.
REQ-037 Memory model holds mem_rdy high (never responds) -> done plus err after TIMEOUT cycles, rdata = 0, FSM returns to IDLE.
REQ-038 rst_n asserted during WAIT_HI of a read -> strobes 0 within the same cycle, no done, next request after release completes normally.
